// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU results against load returns onto one RF write port.
// Optional sub-word load extraction when WB_SUBWORD_LOAD_EN is defined.
module wb_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_result,
  output logic              stall,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              WE3,
  output logic [REG_AW-1:0] A3,
  output logic [DATA_W-1:0] WD3
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } state_t;

  state_t state, state_nx;

  logic [REG_AW-1:0] p_rd;
  logic [2:0]        p_f3;
  logic [1:0]        p_off;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] ext;

  logic              hold_v;
  logic [REG_AW-1:0] hold_rd;
  logic [DATA_W-1:0] hold_d;

  logic              hazard;
  logic              acc;
  logic              sel_v;
  logic [REG_AW-1:0] sel_rd;
  logic [DATA_W-1:0] sel_d;

  // An ALU write to the in-flight load's rd must not overtake it.
  assign hazard = alu_valid && (state != IDLE)
               && (alu_rd == p_rd) && (alu_rd != '0);
  assign stall = hold_v | hazard;
  assign acc = alu_valid & ~stall;
  assign ld_req_ready = (state == IDLE);

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_rdata[8*p_off +: 8];
    half_v = mem_rdata[16*p_off[1] +: 16];
    unique case (p_f3)
      3'b000:  ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
      3'b001:  ext = {{(DATA_W-16){half_v[15]}}, half_v};
      3'b100:  ext = {{(DATA_W-8){1'b0}}, byte_v};
      3'b101:  ext = {{(DATA_W-16){1'b0}}, half_v};
      default: ext = mem_rdata;
    endcase
  end
`else
  logic unused_sub;
  assign unused_sub = ^{p_f3, p_off};
  assign ext = mem_rdata;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (ld_req_valid) state_nx = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid) state_nx = WRITE;
      WRITE:    state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel_v  = 1'b0;
    sel_rd = '0;
    sel_d  = '0;
    unique case (1'b1)
      (state == WRITE): begin
        sel_v  = 1'b1;
        sel_rd = p_rd;
        sel_d  = ld_data;
      end
      (state != WRITE && hold_v): begin
        sel_v  = 1'b1;
        sel_rd = hold_rd;
        sel_d  = hold_d;
      end
      (state != WRITE && !hold_v && acc): begin
        sel_v  = 1'b1;
        sel_rd = alu_rd;
        sel_d  = alu_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      p_rd    <= '0;
      p_f3    <= '0;
      p_off   <= '0;
      ld_data <= '0;
      hold_v  <= 1'b0;
      hold_rd <= '0;
      hold_d  <= '0;
      WE3     <= 1'b0;
      A3      <= '0;
      WD3     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && ld_req_valid) begin
        p_rd  <= ld_rd;
        p_f3  <= ld_funct3;
        p_off <= ld_off;
      end
      if (state == WAIT_MEM && mem_rvalid) ld_data <= ext;
      // Hold captures an ALU write displaced by the load slot.
      if (state == WRITE && acc) begin
        hold_v  <= 1'b1;
        hold_rd <= alu_rd;
        hold_d  <= alu_result;
      end else if (state != WRITE && hold_v) begin
        hold_v <= 1'b0;
      end
      WE3 <= sel_v && (sel_rd != '0);
      if (sel_v) begin
        A3  <= sel_rd;
        WD3 <= sel_d;
      end
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus a randomized run
// against a transaction-level model of the writeback port.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        stall;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  wb_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .stall(stall),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: load phase 0=none, 1=awaiting data, 2=data ready to write.
  int          ph;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic [31:0] m_data;
  logic [4:0]  hq_rd[$];
  logic [31:0] hq_d[$];

  logic        e_stall, e_rdy, e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;
  logic        o_stall, o_rdy;

  function automatic logic [31:0] extract(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
`ifdef WB_SUBWORD_LOAD_EN
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
`else
    return (f3 == f3 && b == b && h == h) ? w : w;
`endif
  endfunction

  task automatic model_reset();
    ph = 0;
    m_rd = '0;
    m_f3 = '0;
    m_off = '0;
    m_data = '0;
    hq_rd.delete();
    hq_d.delete();
  endtask

  // One clock: sample handshakes, advance model, step, settle.
  task automatic cyc();
    logic acc;
    #1;
    o_stall = stall;
    o_rdy = ld_req_ready;
    e_rdy = (ph == 0);
    e_stall = (hq_rd.size() != 0) ||
              (alu_valid && ph != 0 && alu_rd == m_rd && alu_rd != 0);
    acc = alu_valid && !e_stall;
    e_we = 1'b0;
    if (ph == 2) begin
      e_we = (m_rd != 0); e_a3 = m_rd; e_wd = m_data;
      if (acc) begin
        hq_rd.push_back(alu_rd);
        hq_d.push_back(alu_result);
      end
    end else if (hq_rd.size() != 0) begin
      e_a3 = hq_rd.pop_front(); e_wd = hq_d.pop_front();
      e_we = (e_a3 != 0);
    end else if (acc) begin
      e_we = (alu_rd != 0); e_a3 = alu_rd; e_wd = alu_result;
    end
    if (ph == 0 && ld_req_valid) begin
      ph = 1; m_rd = ld_rd; m_f3 = ld_funct3; m_off = ld_off;
    end else if (ph == 1 && mem_rvalid) begin
      ph = 2; m_data = extract(m_f3, m_off, mem_rdata);
    end else if (ph == 2) begin
      ph = 0;
    end
    if (rst) begin
      model_reset();
      e_we = 1'b0; e_a3 = '0; e_wd = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_req_valid = 0; ld_rd = 0; ld_funct3 = 3'd2; ld_off = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    checks++;
    if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: got we=%b a3=%0d wd=%h want 0/0/0", WE3, A3, WD3);
    end
    cyc();
    checks++;
    if (o_stall !== 1'b0 || o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: got stall=%b rdy=%b want 0/1", o_stall, o_rdy);
    end
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 10; alu_result = 12;
    cyc();
    alu_valid = 0;
    checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd10 || WD3 !== 32'd12) begin
      errors++;
      $display("FAIL alu_write: got we=%b a3=%0d wd=%0d want 1/10/12", WE3, A3, WD3);
    end
    cyc();
    checks++;
    if (WE3 !== 1'b0) begin
      errors++;
      $display("FAIL alu_once: got we=%b want 0", WE3);
    end
  endtask

  task automatic test_load_lw();
    int nrdy = 0;
    ld_req_valid = 1; ld_rd = 20; ld_funct3 = 3'd2; ld_off = 0;
    cyc();
    ld_req_valid = 0;
    cyc(); nrdy += o_rdy;
    cyc(); nrdy += o_rdy;
    mem_rvalid = 1; mem_rdata = 32'h0000000F;
    cyc(); nrdy += o_rdy;
    mem_rvalid = 0;
    checks++;
    if (WE3 !== 1'b0) begin
      errors++;
      $display("FAIL load_early: got we=%b want 0", WE3);
    end
    cyc(); nrdy += o_rdy;
    checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd20 || WD3 !== 32'd15) begin
      errors++;
      $display("FAIL load_lw: got we=%b a3=%0d wd=%0d want 1/20/15", WE3, A3, WD3);
    end
    checks++;
    if (nrdy != 0) begin
      errors++;
      $display("FAIL load_rdy: got %0d ready cycles want 0", nrdy);
    end
  endtask

  task automatic test_hazard();
    int nst = 0;
    ld_req_valid = 1; ld_rd = 5; ld_funct3 = 3'd2;
    cyc();
    ld_req_valid = 0;
    alu_valid = 1; alu_rd = 5; alu_result = 32'h55;
    cyc(); nst += o_stall;
    mem_rvalid = 1; mem_rdata = 32'hAA;
    cyc(); nst += o_stall;
    mem_rvalid = 0;
    cyc(); nst += o_stall;
    checks++;
    if (nst != 3 || WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hAA) begin
      errors++;
      $display("FAIL hazard_load: got stalls=%0d we=%b a3=%0d wd=%h want 3/1/5/aa",
               nst, WE3, A3, WD3);
    end
    cyc();
    alu_valid = 0;
    checks++;
    if (o_stall !== 1'b0 || WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h55) begin
      errors++;
      $display("FAIL hazard_alu: got stall=%b we=%b a3=%0d wd=%h want 0/1/5/55",
               o_stall, WE3, A3, WD3);
    end
  endtask

  task automatic test_hold();
    ld_req_valid = 1; ld_rd = 9; ld_funct3 = 3'd2;
    cyc();
    ld_req_valid = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234;
    cyc();
    mem_rvalid = 0;
    alu_valid = 1; alu_rd = 7; alu_result = 3;
    cyc();
    checks++;
    if (o_stall !== 1'b0 || WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'h1234) begin
      errors++;
      $display("FAIL hold_load: got stall=%b we=%b a3=%0d wd=%h want 0/1/9/1234",
               o_stall, WE3, A3, WD3);
    end
    alu_rd = 8; alu_result = 4;
    cyc();
    checks++;
    if (o_stall !== 1'b1 || WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'd3) begin
      errors++;
      $display("FAIL hold_drain: got stall=%b we=%b a3=%0d wd=%0d want 1/1/7/3",
               o_stall, WE3, A3, WD3);
    end
    cyc();
    alu_valid = 0;
    checks++;
    if (o_stall !== 1'b0 || WE3 !== 1'b1 || A3 !== 5'd8 || WD3 !== 32'd4) begin
      errors++;
      $display("FAIL hold_next: got stall=%b we=%b a3=%0d wd=%0d want 0/1/8/4",
               o_stall, WE3, A3, WD3);
    end
  endtask

  task automatic test_subword();
    logic [31:0] want [2];
    logic [2:0]  f3s [2];
    f3s[0] = 3'd0; f3s[1] = 3'd4;
`ifdef WB_SUBWORD_LOAD_EN
    want[0] = 32'hFFFFFF80; want[1] = 32'h00000080;
`else
    want[0] = 32'h80000000; want[1] = 32'h80000000;
`endif
    for (int i = 0; i < 2; i++) begin
      ld_req_valid = 1; ld_rd = 3; ld_funct3 = f3s[i]; ld_off = 2'd3;
      cyc();
      ld_req_valid = 0;
      mem_rvalid = 1; mem_rdata = 32'h80000000;
      cyc();
      mem_rvalid = 0;
      cyc();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== want[i]) begin
        errors++;
        $display("FAIL subword_%0d: got we=%b a3=%0d wd=%h want 1/3/%h",
                 i, WE3, A3, WD3, want[i]);
      end
    end
    alu_valid = 1; alu_rd = 0; alu_result = 99;
    cyc();
    alu_valid = 0;
    checks++;
    if (o_stall !== 1'b0 || WE3 !== 1'b0) begin
      errors++;
      $display("FAIL x0_drop: got stall=%b we=%b want 0/0", o_stall, WE3);
    end
  endtask

  task automatic test_reset_midload();
    int nwe = 0;
    ld_req_valid = 1; ld_rd = 11; ld_funct3 = 3'd2;
    cyc();
    ld_req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_out: got we=%b a3=%0d wd=%h want 0/0/0", WE3, A3, WD3);
    end
    mem_rvalid = 1; mem_rdata = 32'hDEAD;
    cyc(); nwe += WE3;
    mem_rvalid = 0;
    checks++;
    if (o_rdy !== 1'b1 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hs: got rdy=%b stall=%b want 1/0", o_rdy, o_stall);
    end
    cyc(); nwe += WE3;
    cyc(); nwe += WE3;
    checks++;
    if (nwe != 0) begin
      errors++;
      $display("FAIL rst_mid_we: got %0d writes want 0", nwe);
    end
  endtask

  task automatic test_random();
    logic [2:0] f3tab [5];
    f3tab[0] = 3'd0; f3tab[1] = 3'd1; f3tab[2] = 3'd2;
    f3tab[3] = 3'd4; f3tab[4] = 3'd5;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!(alu_valid && e_stall)) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rd = 5'($urandom_range(0, 7));
        alu_result = $urandom;
      end
      if (!(ld_req_valid && !e_rdy)) begin
        ld_req_valid = ($urandom_range(0, 9) < 3);
        ld_rd = 5'($urandom_range(0, 7));
        ld_funct3 = f3tab[$urandom_range(0, 4)];
        ld_off = 2'($urandom_range(0, 3));
      end
      mem_rvalid = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      cyc();
      checks++;
      if (!rst && (o_stall !== e_stall || o_rdy !== e_rdy)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: got stall=%b rdy=%b want %b/%b",
                 n, o_stall, o_rdy, e_stall, e_rdy);
      end
      checks++;
      if (WE3 !== e_we || (e_we && (A3 !== e_a3 || WD3 !== e_wd))) begin
        errors++;
        $display("FAIL rand_wr[%0d]: got we=%b a3=%0d wd=%h want %b/%0d/%h",
                 n, WE3, A3, WD3, e_we, e_a3, e_wd);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    model_reset();
    e_stall = 0; e_rdy = 1;
    test_reset();
    test_alu_write();
    test_load_lw();
    test_hazard();
    test_hold();
    test_subword();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
